mem_lsu: RTL and testbench
==========================

Name: mem_lsu

Overview:
- Memory-stage load/store unit, directly downstream of the EX/MEM pipeline register.
- Consumes the EX/MEM outputs: address, store data, instruction, mem read/write enables and valid.
- Runs a req/ack handshake to data memory, with byte-lane steering, load extension, misalignment detection and a timeout.
- Stalls the pipeline while an access is outstanding and delivers aligned load data to MEM/WB.

Parameters:
- P_TIMEOUT, 16, max cycles in BUSY waiting for i_dmem_ack before abort (≥2).
- P_TW, 5, width of timeout counter (2**P_TW > P_TIMEOUT).

Ports:
- i_clk  in  1  clock, rising edge
- i_reset  in  1  synchronous active-low reset
- i_addr  in  32  byte address (EX/MEM alu_data)
- i_rs2_data  in  32  store data
- i_instr  in  32  instruction; funct3 = [14:12]
- i_mem_ren  in  1  load request
- i_mem_wren  in  1  store request
- i_insn_vld  in  1  instruction valid
- o_dmem_req  out  1  memory request, held until ack
- o_dmem_we  out  1  1 = write
- o_dmem_addr  out  32  word address ({i_addr[31:2],2'b00})
- o_dmem_wdata  out  32  lane-replicated store data
- o_dmem_bmask  out  4  byte enables
- i_dmem_ack  in  1  access complete; rdata valid same cycle
- i_dmem_rdata  in  32  raw read word
- o_ld_data  out  32  aligned, extended load result
- o_ld_vld  out  1  one-cycle pulse: o_ld_data valid
- o_stall  out  1  hold IF..EX/MEM while high
- o_misalign  out  1  misaligned/illegal access flag (combinational)
- o_err  out  1  one-cycle pulse on timeout abort

Behaviour:
- Access = i_insn_vld & (i_mem_ren | i_mem_wren).
  - Both enables high: treated as a store.
- funct3 decode:
  - 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
  - Any other funct3 with an access → illegal.
- Misalign/illegal:
  - Half access with addr[0]=1, word access with addr[1:0]≠0, or illegal funct3.
  - o_misalign=1 combinationally in IDLE; no request issued; no stall.
- FSM states IDLE, BUSY, DONE; all state and outputs registered except o_stall and o_misalign.
- IDLE:
  - Good access → o_stall=1 this cycle.
  - Next edge: latch we/addr/wdata/bmask/funct3/addr[1:0], o_dmem_req←1, go to BUSY.
- BUSY:
  - o_stall=1; request fields held constant; timeout counter increments each cycle.
  - i_dmem_ack=1 → capture extended load data (loads only), o_dmem_req←0, go to DONE.
  - Counter = P_TIMEOUT-1 without ack → o_dmem_req←0, o_ld_data←0, o_err←1, go to DONE.
  - Ack and timeout in the same cycle: ack wins.
- DONE:
  - o_ld_vld=1 for loads only; o_stall=0 so the pipeline advances at this edge.
  - Never accepts a new access; unconditional return to IDLE.
  - o_ld_vld/o_err clear next cycle; o_ld_data holds until the next capture.
- Minimum access latency: 3 cycles (accept, BUSY+ack, DONE).
- Upstream holds its inputs stable while o_stall=1.
- Store lanes:
  - SB: bmask=4'b0001<<addr[1:0], wdata={4{rs2[7:0]}}.
  - SH: bmask=4'b0011<<{addr[1],1'b0}, wdata={2{rs2[15:0]}}.
  - SW: bmask=4'b1111, wdata=rs2.
  - Loads: bmask=4'b1111, we=0.
- Load extract from the latched addr[1:0]:
  - LB/LH: sign-extend; LBU/LHU: zero-extend; LW: unchanged.
- Reset (any state, including mid-BUSY): next edge → IDLE, counter 0.
  - All registered outputs (o_dmem_req, o_dmem_we, o_dmem_addr, o_dmem_wdata, o_dmem_bmask, o_ld_data, o_ld_vld, o_err) = 0.
  - o_stall/o_misalign follow the IDLE decode.
  - A late ack after reset or abort is ignored in IDLE.

Decomposition:
- Package lsu_pkg: state enum (IDLE/BUSY/DONE) and funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU).
- Sub-module ld_align: combinational extract/extend of the read word from funct3 and addr[1:0].

Test Plan:
- LW addr 0x100, rdata 0xDEADBEEF, ack on 1st BUSY cycle → req 1 cycle; o_ld_data=0xDEADBEEF with o_ld_vld in DONE; o_stall high exactly 2 cycles.
- LB addr 0x103, rdata 0x80FF_0000 → o_ld_data=0xFFFFFF80; LBU same inputs → 0x00000080.
- SH addr 0x202, rs2 0x1234ABCD → o_dmem_we=1, bmask=4'b1100, wdata=0xABCDABCD, addr=0x200; o_ld_vld stays 0.
- LW addr 0x101 → o_misalign=1, o_dmem_req never asserts, o_stall=0; funct3=011 load → same response.
- No ack with P_TIMEOUT=16 → req drops after 16 BUSY cycles, o_err pulses once, o_ld_data=0, FSM returns to IDLE.
- i_reset=0 for one cycle mid-BUSY → next cycle req=0 and state IDLE; a following ack pulse produces no o_ld_vld.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and constants for the memory-stage load/store unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // True when an access with this funct3/address cannot be issued:
    // unknown size, unsigned store variant, or a half/word not naturally aligned.
    function automatic logic access_bad(input logic [2:0] f3,
                                        input logic       store,
                                        input logic [1:0] lo);
        logic bad;
        bad = 1'b0;
        case (f3)
            F3_B:  bad = 1'b0;
            F3_H:  bad = lo[0];
            F3_W:  bad = (lo != 2'b00);
            F3_BU: bad = store;
            F3_HU: bad = store | lo[0];
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/ld_align.sv
// Extracts the addressed byte/half/word from a raw read word and extends it.
// Latency: combinational.
// Backpressure: none.
// Ports: funct3 (access size/signedness), addr_lo (byte offset), rdata (raw word),
//        data (aligned, extended result).
module ld_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] rdata,
    output logic [31:0] data
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = rdata[7:0];
        case (addr_lo)
            2'd0: byte_v = rdata[7:0];
            2'd1: byte_v = rdata[15:8];
            2'd2: byte_v = rdata[23:16];
            2'd3: byte_v = rdata[31:24];
            default: byte_v = rdata[7:0];
        endcase
        half_v = addr_lo[1] ? rdata[31:16] : rdata[15:0];

        data = rdata;
        case (funct3)
            F3_B:  data = {{24{byte_v[7]}}, byte_v};
            F3_BU: data = {24'd0, byte_v};
            F3_H:  data = {{16{half_v[15]}}, half_v};
            F3_HU: data = {16'd0, half_v};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// Memory-stage load/store unit: req/ack data-memory handshake, lane steering, load extension, timeout.
// Latency: 3 cycles minimum (accept, BUSY with ack, DONE); abort after P_TIMEOUT BUSY cycles.
// Backpressure: o_stall holds the pipeline from accept until DONE; DONE never accepts a new access.
// Ports: i_clk/i_reset (sync, active-low); EX/MEM inputs i_addr/i_rs2_data/i_instr/i_mem_ren/
//        i_mem_wren/i_insn_vld; dmem bus o_dmem_*/i_dmem_ack/i_dmem_rdata; MEM/WB outputs
//        o_ld_data/o_ld_vld; control o_stall, o_misalign (combinational), o_err (abort pulse).
module mem_lsu
    import lsu_pkg::*;
#(
    parameter int P_TIMEOUT = 16,
    parameter int P_TW      = 5
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_rs2_data,
    input  logic [31:0] i_instr,
    input  logic        i_mem_ren,
    input  logic        i_mem_wren,
    input  logic        i_insn_vld,
    output logic        o_dmem_req,
    output logic        o_dmem_we,
    output logic [31:0] o_dmem_addr,
    output logic [31:0] o_dmem_wdata,
    output logic [3:0]  o_dmem_bmask,
    input  logic        i_dmem_ack,
    input  logic [31:0] i_dmem_rdata,
    output logic [31:0] o_ld_data,
    output logic        o_ld_vld,
    output logic        o_stall,
    output logic        o_misalign,
    output logic        o_err
);

    localparam logic [P_TW-1:0] TMO_LAST = P_TW'(P_TIMEOUT - 1);

    lsu_state_e      state;
    lsu_state_e      state_nxt;
    logic [P_TW-1:0] tmo_cnt;
    logic            tmo_hit;

    logic [2:0]  f3;
    logic        access;
    logic        is_store;
    logic        bad;
    logic        good;
    logic [3:0]  st_bmask;
    logic [31:0] st_wdata;

    logic [2:0]  f3_q;
    logic [1:0]  lo_q;
    logic [31:0] aligned;

    assign f3       = i_instr[14:12];
    assign access   = i_insn_vld & (i_mem_ren | i_mem_wren);
    // With both enables raised the access is a store.
    assign is_store = i_mem_wren;
    assign bad      = access & access_bad(f3, is_store, i_addr[1:0]);
    assign good     = access & ~bad;

    // Store lane steering; loads always read the full word.
    always_comb begin
        st_bmask = 4'b1111;
        st_wdata = 32'd0;
        if (is_store) begin
            case (f3)
                F3_B: begin
                    st_bmask = 4'b0001 << i_addr[1:0];
                    st_wdata = {4{i_rs2_data[7:0]}};
                end
                F3_H: begin
                    st_bmask = 4'b0011 << {i_addr[1], 1'b0};
                    st_wdata = {2{i_rs2_data[15:0]}};
                end
                default: begin
                    st_bmask = 4'b1111;
                    st_wdata = i_rs2_data;
                end
            endcase
        end
    end

    ld_align u_ld_align (
        .funct3  (f3_q),
        .addr_lo (lo_q),
        .rdata   (i_dmem_rdata),
        .data    (aligned)
    );

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        o_stall    = 1'b0;
        o_misalign = 1'b0;
        tmo_hit    = 1'b0;
        case (state)
            IDLE: begin
                o_misalign = bad;
                o_stall    = good;
                if (good) begin
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                o_stall = 1'b1;
                // An ack arriving on the last allowed cycle still completes normally.
                if (i_dmem_ack) begin
                    state_nxt = DONE;
                end else if (tmo_cnt == TMO_LAST) begin
                    tmo_hit   = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            tmo_cnt      <= '0;
            o_dmem_req   <= 1'b0;
            o_dmem_we    <= 1'b0;
            o_dmem_addr  <= 32'd0;
            o_dmem_wdata <= 32'd0;
            o_dmem_bmask <= 4'd0;
            f3_q         <= 3'd0;
            lo_q         <= 2'd0;
            o_ld_data    <= 32'd0;
            o_ld_vld     <= 1'b0;
            o_err        <= 1'b0;
        end else begin
            o_ld_vld <= 1'b0;
            o_err    <= 1'b0;
            tmo_cnt  <= '0;
            case (state)
                IDLE: begin
                    if (good) begin
                        o_dmem_req   <= 1'b1;
                        o_dmem_we    <= is_store;
                        o_dmem_addr  <= {i_addr[31:2], 2'b00};
                        o_dmem_wdata <= st_wdata;
                        o_dmem_bmask <= st_bmask;
                        f3_q         <= f3;
                        lo_q         <= i_addr[1:0];
                    end
                end
                BUSY: begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                    if (i_dmem_ack) begin
                        o_dmem_req <= 1'b0;
                        if (!o_dmem_we) begin
                            o_ld_data <= aligned;
                            o_ld_vld  <= 1'b1;
                        end
                    end else if (tmo_hit) begin
                        o_dmem_req <= 1'b0;
                        o_ld_data  <= 32'd0;
                        o_err      <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_lsu.sv
// Self-checking bench for mem_lsu: vector table plus scoreboard of expected completions.
// Latency: n/a.
// Backpressure: bench holds inputs while o_stall is high.
module tb_mem_lsu;
    import lsu_pkg::*;

    localparam int P_TIMEOUT = 16;
    localparam int P_TW      = 5;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b0;
    logic [31:0] i_addr = 32'd0;
    logic [31:0] i_rs2_data = 32'd0;
    logic [31:0] i_instr = 32'd0;
    logic        i_mem_ren = 1'b0;
    logic        i_mem_wren = 1'b0;
    logic        i_insn_vld = 1'b0;
    logic        o_dmem_req;
    logic        o_dmem_we;
    logic [31:0] o_dmem_addr;
    logic [31:0] o_dmem_wdata;
    logic [3:0]  o_dmem_bmask;
    logic        i_dmem_ack = 1'b0;
    logic [31:0] i_dmem_rdata = 32'd0;
    logic [31:0] o_ld_data;
    logic        o_ld_vld;
    logic        o_stall;
    logic        o_misalign;
    logic        o_err;

    mem_lsu #(.P_TIMEOUT(P_TIMEOUT), .P_TW(P_TW)) dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_addr       (i_addr),
        .i_rs2_data   (i_rs2_data),
        .i_instr      (i_instr),
        .i_mem_ren    (i_mem_ren),
        .i_mem_wren   (i_mem_wren),
        .i_insn_vld   (i_insn_vld),
        .o_dmem_req   (o_dmem_req),
        .o_dmem_we    (o_dmem_we),
        .o_dmem_addr  (o_dmem_addr),
        .o_dmem_wdata (o_dmem_wdata),
        .o_dmem_bmask (o_dmem_bmask),
        .i_dmem_ack   (i_dmem_ack),
        .i_dmem_rdata (i_dmem_rdata),
        .o_ld_data    (o_ld_data),
        .o_ld_vld     (o_ld_vld),
        .o_stall      (o_stall),
        .o_misalign   (o_misalign),
        .o_err        (o_err)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [2:0]  f3;
        logic        ren;
        logic        wren;
        logic [31:0] addr;
        logic [31:0] rs2;
        logic [31:0] rdata;
        int          ack_dly;   // BUSY cycle index carrying the ack, -1 = never
        logic        misal;
        logic        we;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic [3:0]  e_bmask;
        logic [31:0] e_ld;
        logic        e_vld;
        logic        e_err;
        int          e_busy;
    } vec_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  bmask;
        logic        vld;
        logic        err;
        logic [31:0] ld;
    } exp_t;

    vec_t tbl[15];
    exp_t sb_q[$];
    exp_t cur;
    logic prev_req = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", name, act, exp, $time);
        end
    endfunction

    // Scoreboard: request fields checked when req rises, completion when it falls.
    always @(negedge i_clk) begin
        if (o_dmem_req && !prev_req) begin
            chk("req_has_exp", 32'(sb_q.size() > 0), 32'd1);
            if (sb_q.size() > 0) begin
                chk("req_we", 32'(o_dmem_we), 32'(sb_q[0].we));
                chk("req_addr", o_dmem_addr, sb_q[0].addr);
                chk("req_bmask", 32'(o_dmem_bmask), 32'(sb_q[0].bmask));
                if (sb_q[0].we) chk("req_wdata", o_dmem_wdata, sb_q[0].wdata);
            end
        end
        if (!o_dmem_req && prev_req) begin
            chk("cpl_has_exp", 32'(sb_q.size() > 0), 32'd1);
            if (sb_q.size() > 0) begin
                cur = sb_q.pop_front();
                chk("cpl_ld_vld", 32'(o_ld_vld), 32'(cur.vld));
                chk("cpl_err", 32'(o_err), 32'(cur.err));
                chk("cpl_ld_data", o_ld_data, cur.ld);
            end
        end else begin
            chk("no_pulse", 32'({o_ld_vld, o_err}), 32'd0);
        end
        prev_req = o_dmem_req;
    end

    task automatic drive(input vec_t v);
        i_insn_vld   = 1'b1;
        i_mem_ren    = v.ren;
        i_mem_wren   = v.wren;
        i_instr      = {17'd0, v.f3, 12'd0};
        i_addr       = v.addr;
        i_rs2_data   = v.rs2;
        i_dmem_rdata = v.rdata;
    endtask

    task automatic idle_inputs();
        i_insn_vld = 1'b0;
        i_mem_ren  = 1'b0;
        i_mem_wren = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        int   stall_cnt;
        int   busy;
        logic done;
        exp_t e;
        stall_cnt = 0;
        busy      = 0;
        done      = 1'b0;
        @(posedge i_clk); #1;
        drive(v);
        if (v.misal) begin
            @(negedge i_clk);
            chk("misalign_flag", 32'(o_misalign), 32'd1);
            chk("misalign_stall", 32'(o_stall), 32'd0);
            for (int k = 0; k < 3; k++) begin
                @(negedge i_clk);
                chk("misalign_noreq", 32'(o_dmem_req), 32'd0);
            end
            @(posedge i_clk); #1;
        end else begin
            e = '{v.we, v.e_addr, v.e_wdata, v.e_bmask, v.e_vld, v.e_err, v.e_ld};
            sb_q.push_back(e);
            for (int cyc = 0; cyc < P_TIMEOUT + 8 && !done; cyc++) begin
                @(negedge i_clk);
                if (cyc == 0) chk("good_no_misalign", 32'(o_misalign), 32'd0);
                if (o_stall) stall_cnt++;
                if (o_dmem_req) begin
                    if (busy == v.ack_dly) i_dmem_ack = 1'b1;
                    busy++;
                end else if (busy > 0) begin
                    done = 1'b1;
                end
                @(posedge i_clk); #1;
                i_dmem_ack = 1'b0;
            end
            chk("access_completes", 32'(done), 32'd1);
            chk("busy_cycles", busy, v.e_busy);
            chk("stall_cycles", stall_cnt, v.e_busy + 1);
        end
        idle_inputs();
        @(posedge i_clk); #1;
    endtask

    initial begin
        //            f3     ren   wren  addr          rs2           rdata         dly mis   we    e_addr        e_wdata       bm       e_ld          vld   err   busy
        tbl[0]  = '{F3_W,  1'b1, 1'b0, 32'h0000_0100, 32'h0,        32'hDEADBEEF, 0,  1'b0, 1'b0, 32'h0000_0100, 32'h0,        4'hF, 32'hDEADBEEF, 1'b1, 1'b0, 1};
        tbl[1]  = '{F3_B,  1'b1, 1'b0, 32'h0000_0103, 32'h0,        32'h80FF_0000, 0, 1'b0, 1'b0, 32'h0000_0100, 32'h0,        4'hF, 32'hFFFF_FF80, 1'b1, 1'b0, 1};
        tbl[2]  = '{F3_BU, 1'b1, 1'b0, 32'h0000_0103, 32'h0,        32'h80FF_0000, 0, 1'b0, 1'b0, 32'h0000_0100, 32'h0,        4'hF, 32'h0000_0080, 1'b1, 1'b0, 1};
        tbl[3]  = '{F3_H,  1'b1, 1'b0, 32'h0000_0102, 32'h0,        32'h8001_1234, 2, 1'b0, 1'b0, 32'h0000_0100, 32'h0,        4'hF, 32'hFFFF_8001, 1'b1, 1'b0, 3};
        tbl[4]  = '{F3_HU, 1'b1, 1'b0, 32'h0000_0100, 32'h0,        32'h8001_F234, 1, 1'b0, 1'b0, 32'h0000_0100, 32'h0,        4'hF, 32'h0000_F234, 1'b1, 1'b0, 2};
        tbl[5]  = '{F3_B,  1'b1, 1'b0, 32'h0000_0101, 32'h0,        32'h0000_7F00, 0, 1'b0, 1'b0, 32'h0000_0100, 32'h0,        4'hF, 32'h0000_007F, 1'b1, 1'b0, 1};
        tbl[6]  = '{F3_H,  1'b0, 1'b1, 32'h0000_0202, 32'h1234ABCD, 32'hFFFF_FFFF, 0, 1'b0, 1'b1, 32'h0000_0200, 32'hABCDABCD, 4'hC, 32'h0000_007F, 1'b0, 1'b0, 1};
        tbl[7]  = '{F3_B,  1'b0, 1'b1, 32'h0000_0301, 32'h0000_00A5, 32'h0,        1, 1'b0, 1'b1, 32'h0000_0300, 32'hA5A5A5A5, 4'h2, 32'h0000_007F, 1'b0, 1'b0, 2};
        tbl[8]  = '{F3_W,  1'b1, 1'b1, 32'h0000_0404, 32'hCAFEF00D, 32'h0,        0, 1'b0, 1'b1, 32'h0000_0404, 32'hCAFEF00D, 4'hF, 32'h0000_007F, 1'b0, 1'b0, 1};
        tbl[9]  = '{F3_W,  1'b1, 1'b0, 32'h0000_0101, 32'h0,        32'h0,        0, 1'b1, 1'b0, 32'h0,        32'h0,        4'h0, 32'h0,        1'b0, 1'b0, 0};
        tbl[10] = '{3'b011, 1'b1, 1'b0, 32'h0000_0100, 32'h0,       32'h0,        0, 1'b1, 1'b0, 32'h0,        32'h0,        4'h0, 32'h0,        1'b0, 1'b0, 0};
        tbl[11] = '{F3_H,  1'b1, 1'b0, 32'h0000_0103, 32'h0,        32'h0,        0, 1'b1, 1'b0, 32'h0,        32'h0,        4'h0, 32'h0,        1'b0, 1'b0, 0};
        tbl[12] = '{F3_W,  1'b0, 1'b1, 32'h0000_0102, 32'h0,        32'h0,        0, 1'b1, 1'b0, 32'h0,        32'h0,        4'h0, 32'h0,        1'b0, 1'b0, 0};
        tbl[13] = '{F3_W,  1'b1, 1'b0, 32'h0000_0500, 32'h0,        32'h5555_5555, -1, 1'b0, 1'b0, 32'h0000_0500, 32'h0,       4'hF, 32'h0,        1'b0, 1'b1, 16};
        tbl[14] = '{F3_W,  1'b1, 1'b0, 32'h0000_0504, 32'h0,        32'h1122_3344, 15, 1'b0, 1'b0, 32'h0000_0504, 32'h0,       4'hF, 32'h1122_3344, 1'b1, 1'b0, 16};

        // Reset state
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        chk("rst_req", 32'(o_dmem_req), 32'd0);
        chk("rst_we", 32'(o_dmem_we), 32'd0);
        chk("rst_addr", o_dmem_addr, 32'd0);
        chk("rst_wdata", o_dmem_wdata, 32'd0);
        chk("rst_bmask", 32'(o_dmem_bmask), 32'd0);
        chk("rst_ld_data", o_ld_data, 32'd0);
        chk("rst_ld_vld", 32'(o_ld_vld), 32'd0);
        chk("rst_err", 32'(o_err), 32'd0);
        chk("rst_stall", 32'(o_stall), 32'd0);
        chk("rst_misalign", 32'(o_misalign), 32'd0);
        @(posedge i_clk); #1;
        i_reset = 1'b1;

        for (int i = 0; i < 15; i++) begin
            run_vec(tbl[i]);
        end

        // Reset mid-BUSY, then a late ack that must be ignored.
        begin
            vec_t v;
            exp_t e;
            logic seen;
            v = tbl[0];
            v.addr = 32'h0000_0600;
            drive(v);
            e = '{1'b0, 32'h0000_0600, 32'h0, 4'hF, 1'b0, 1'b0, 32'h0};
            sb_q.push_back(e);
            seen = 1'b0;
            for (int k = 0; k < 5 && !seen; k++) begin
                @(negedge i_clk);
                seen = o_dmem_req;
            end
            chk("rstseq_req_seen", 32'(seen), 32'd1);
            @(posedge i_clk); #1;
            i_reset = 1'b0;
            idle_inputs();
            @(posedge i_clk); #1;
            i_reset = 1'b1;
            @(negedge i_clk);
            chk("rstseq_req_low", 32'(o_dmem_req), 32'd0);
            chk("rstseq_idle_nostall", 32'(o_stall), 32'd0);
            i_dmem_ack = 1'b1;
            @(posedge i_clk); #1;
            i_dmem_ack = 1'b0;
            for (int k = 0; k < 3; k++) begin
                @(negedge i_clk);
                chk("rstseq_late_ack_vld", 32'(o_ld_vld), 32'd0);
                chk("rstseq_late_ack_req", 32'(o_dmem_req), 32'd0);
            end
        end

        // Counter must restart from zero after the reset.
        run_vec(tbl[14]);

        chk("sb_drained", sb_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
